// File: rtl/kamus_dmem_if.sv
// -----------------------------------------------------------------------------
// kamus_dmem_if
//
// Bridges the LSU to a request/grant/response data-memory bus. The unit
// accepts one access at a time. Misaligned or illegal-width accesses are
// rejected without touching the bus. All other accesses are issued as a
// single word-aligned bus transfer: byte enables select the lanes, and store
// data is replicated across the lanes. Load data is pulled out of the
// addressed lane and then sign- or zero-extended.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   lsu_req_i               LSU access request (sampled only while idle)
//   lsu_we_i                1 = store, 0 = load
//   lsu_width_i             00 byte, 01 half, 10 word, 11 illegal
//   lsu_unsigned_i          zero-extend loads when 1, sign-extend when 0
//   lsu_addr_i              byte address
//   lsu_wdata_i             right-aligned store data
//   lsu_busy_o              high while a bus access is outstanding
//   lsu_done_o              one-cycle completion pulse
//   lsu_rdata_o             extended load data, valid with lsu_done_o
//   lsu_err_o               one-cycle error pulse (alignment/width/bus)
//   data_req_o/data_gnt_i   bus request handshake
//   data_addr_o             word-aligned bus address
//   data_we_o, data_be_o    bus write enable and byte enables
//   data_wdata_o            lane-replicated store data
//   data_rvalid_i           bus response valid
//   data_rdata_i            bus read data
//   data_err_i              bus error, qualified by data_rvalid_i
// -----------------------------------------------------------------------------
module kamus_dmem_if (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_width_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Illegal width or an address that is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] width,
                                           input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (width)
            WIDTH_B: bad = 1'b0;
            WIDTH_H: bad = addr_lo[0];
            WIDTH_W: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] width,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (width)
            WIDTH_B: be = 4'b0001 << addr_lo;
            WIDTH_H: be = 4'b0011 << addr_lo;
            WIDTH_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicating the data means the memory needs no shifter: whichever
    // lanes are enabled already carry the right bytes.
    function automatic logic [31:0] replicate_wdata(input logic [1:0]  width,
                                                    input logic [31:0] wdata);
        logic [31:0] rep;
        rep = wdata;
        case (width)
            WIDTH_B: rep = {4{wdata[7:0]}};
            WIDTH_H: rep = {2{wdata[15:0]}};
            WIDTH_W: rep = wdata;
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] extract_load(input logic [1:0]  width,
                                                 input logic        uns,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [31:0] rdata);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] ext;
        lane_b = rdata[{addr_lo, 3'b000} +: 8];
        // Half accesses are 2-byte aligned here, so only addr_lo[1] picks the lane.
        lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];
        ext    = rdata;
        case (width)
            WIDTH_B: ext = uns ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
            WIDTH_H: ext = uns ? {16'h0000, lane_h}   : {{16{lane_h[15]}}, lane_h};
            WIDTH_W: ext = rdata;
            default: ext = rdata;
        endcase
        return ext;
    endfunction

    state_t      state_r, state_s;
    logic        we_r, we_s;
    logic [1:0]  width_r, width_s;
    logic        unsigned_r, unsigned_s;
    logic [1:0]  addr_lo_r, addr_lo_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic [31:0] rdata_r, rdata_s;
    logic        data_req_r, data_req_s;
    logic [31:0] data_addr_r, data_addr_s;
    logic        data_we_r, data_we_s;
    logic [3:0]  data_be_r, data_be_s;
    logic [31:0] data_wdata_r, data_wdata_s;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s      = state_r;
        we_s         = we_r;
        width_s      = width_r;
        unsigned_s   = unsigned_r;
        addr_lo_s    = addr_lo_r;
        done_s       = 1'b0;
        err_s        = 1'b0;
        rdata_s      = rdata_r;
        data_req_s   = data_req_r;
        data_addr_s  = data_addr_r;
        data_we_s    = data_we_r;
        data_be_s    = data_be_r;
        data_wdata_s = data_wdata_r;

        case (state_r)
            ST_IDLE: begin
                if (lsu_req_i) begin
                    if (is_misaligned(lsu_width_i, lsu_addr_i[1:0])) begin
                        // Rejected access completes immediately and never leaves IDLE.
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        we_s         = lsu_we_i;
                        width_s      = lsu_width_i;
                        unsigned_s   = lsu_unsigned_i;
                        addr_lo_s    = lsu_addr_i[1:0];
                        data_req_s   = 1'b1;
                        data_addr_s  = {lsu_addr_i[31:2], 2'b00};
                        data_we_s    = lsu_we_i;
                        data_be_s    = byte_enables(lsu_width_i, lsu_addr_i[1:0]);
                        data_wdata_s = replicate_wdata(lsu_width_i, lsu_wdata_i);
                        state_s      = ST_REQ;
                    end
                end else begin
                    data_req_s = 1'b0;
                    state_s    = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (data_gnt_i) begin
                    data_req_s = 1'b0;
                    state_s    = ST_RESP;
                end else begin
                    // Request attributes are frozen until the grant arrives.
                    data_req_s = 1'b1;
                    state_s    = ST_REQ;
                end
            end
            ST_RESP: begin
                if (data_rvalid_i) begin
                    done_s  = 1'b1;
                    err_s   = data_err_i;
                    state_s = ST_IDLE;
                    if (!we_r && !data_err_i) begin
                        rdata_s = extract_load(width_r, unsigned_r, addr_lo_r, data_rdata_i);
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                data_req_s = 1'b0;
                state_s    = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            we_r         <= 1'b0;
            width_r      <= 2'b00;
            unsigned_r   <= 1'b0;
            addr_lo_r    <= 2'b00;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            rdata_r      <= 32'h0000_0000;
            data_req_r   <= 1'b0;
            data_addr_r  <= 32'h0000_0000;
            data_we_r    <= 1'b0;
            data_be_r    <= 4'b0000;
            data_wdata_r <= 32'h0000_0000;
        end else begin
            state_r      <= state_s;
            we_r         <= we_s;
            width_r      <= width_s;
            unsigned_r   <= unsigned_s;
            addr_lo_r    <= addr_lo_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            err_r        <= err_s;
            rdata_r      <= rdata_s;
            data_req_r   <= data_req_s;
            data_addr_r  <= data_addr_s;
            data_we_r    <= data_we_s;
            data_be_r    <= data_be_s;
            data_wdata_r <= data_wdata_s;
        end
    end

    assign lsu_busy_o   = busy_r;
    assign lsu_done_o   = done_r;
    assign lsu_err_o    = err_r;
    assign lsu_rdata_o  = rdata_r;
    assign data_req_o   = data_req_r;
    assign data_addr_o  = data_addr_r;
    assign data_we_o    = data_we_r;
    assign data_be_o    = data_be_r;
    assign data_wdata_o = data_wdata_r;

endmodule

// File: tb/tb_kamus_dmem_if.sv
// -----------------------------------------------------------------------------
// tb_kamus_dmem_if
//
// Self-checking bench for kamus_dmem_if. The bench plays the role of the bus
// slave. Expected values come from a transaction-level model written with
// plain arithmetic.
// -----------------------------------------------------------------------------
module tb_kamus_dmem_if;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_width_i;
    logic        lsu_unsigned_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_rdata;

    kamus_dmem_if dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_width_i    (lsu_width_i),
        .lsu_unsigned_i (lsu_unsigned_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_busy_o     (lsu_busy_o),
        .lsu_done_o     (lsu_done_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_err_o      (lsu_err_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_addr_o    (data_addr_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_wdata_o   (data_wdata_o),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i),
        .data_err_i     (data_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_bad(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd3) return 1'b1;
        if (w == 2'd1) return (a % 2) != 0;
        if (w == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] w, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        if (w == 2'd0) return 4'(1 << off);
        if (w == 2'd1) return 4'(3 << off);
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] w, input logic [31:0] d);
        if (w == 2'd0) return (d % 256) * 32'h0101_0101;
        if (w == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] w, input logic u,
                                             input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        v = d >> (8 * (a % 4));
        if (w == 2'd0) begin
            v = v % 256;
            if (!u && v >= 32'd128) v = v - 32'd256;
        end else if (w == 2'd1) begin
            v = v % 65536;
            if (!u && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // ---------------- transaction driver / checker ----------------
    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic run_txn(input logic we, input logic [1:0] w, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gnt_dly, input int rv_dly,
                           input logic berr, input logic [31:0] rd);
        logic bad;
        bad = ref_bad(w, a);
        lsu_req_i      = 1'b1;
        lsu_we_i       = we;
        lsu_width_i    = w;
        lsu_unsigned_i = u;
        lsu_addr_i     = a;
        lsu_wdata_i    = wd;
        @(posedge clk);
        @(negedge clk);
        // Scramble the LSU inputs so that only latched values can be correct.
        lsu_req_i      = 1'b0;
        lsu_we_i       = ~we;
        lsu_width_i    = 2'($urandom);
        lsu_unsigned_i = ~u;
        lsu_addr_i     = $urandom;
        lsu_wdata_i    = $urandom;
        if (bad) begin
            chk("rej_err",   lsu_err_o,   32'd1);
            chk("rej_done",  lsu_done_o,  32'd1);
            chk("rej_busy",  lsu_busy_o,  32'd0);
            chk("rej_req",   data_req_o,  32'd0);
            chk("rej_rdata", lsu_rdata_o, model_rdata);
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                chk("req_req",  data_req_o,  32'd1);
                chk("req_busy", lsu_busy_o,  32'd1);
                chk("req_done", lsu_done_o,  32'd0);
                chk("req_addr", data_addr_o, {a[31:2], 2'b00});
                chk("req_be",   data_be_o,   ref_be(w, a));
                chk("req_we",   data_we_o,   we);
                if (we) chk("req_wdata", data_wdata_o, ref_wdata(w, wd));
                data_gnt_i    = (i == gnt_dly);
                data_rvalid_i = 1'($urandom);
                data_err_i    = 1'($urandom);
                data_rdata_i  = $urandom;
                @(posedge clk);
                @(negedge clk);
            end
            data_gnt_i = 1'b0;
            for (int i = 0; i <= rv_dly; i++) begin
                chk("resp_req",  data_req_o, 32'd0);
                chk("resp_busy", lsu_busy_o, 32'd1);
                chk("resp_done", lsu_done_o, 32'd0);
                data_rvalid_i = (i == rv_dly);
                data_err_i    = (i == rv_dly) ? berr : 1'b0;
                data_rdata_i  = (i == rv_dly) ? rd : $urandom;
                data_gnt_i    = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
            end
            data_rvalid_i = 1'b0;
            data_gnt_i    = 1'b0;
            data_err_i    = 1'b0;
            if (!we && !berr) model_rdata = ref_load(w, u, a, rd);
            chk("fin_done",  lsu_done_o,  32'd1);
            chk("fin_err",   lsu_err_o,   berr);
            chk("fin_busy",  lsu_busy_o,  32'd0);
            chk("fin_req",   data_req_o,  32'd0);
            chk("fin_rdata", lsu_rdata_o, model_rdata);
        end
        // One idle cycle with stray bus responses that must be ignored.
        data_rvalid_i = 1'($urandom);
        data_gnt_i    = 1'($urandom);
        data_err_i    = 1'($urandom);
        data_rdata_i  = $urandom;
        @(posedge clk);
        @(negedge clk);
        data_rvalid_i = 1'b0;
        data_gnt_i    = 1'b0;
        data_err_i    = 1'b0;
        chk("idle_done",  lsu_done_o,  32'd0);
        chk("idle_err",   lsu_err_o,   32'd0);
        chk("idle_busy",  lsu_busy_o,  32'd0);
        chk("idle_req",   data_req_o,  32'd0);
        chk("idle_rdata", lsu_rdata_o, model_rdata);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  lsu_busy_o,   32'd0);
        chk({tag, "_done"},  lsu_done_o,   32'd0);
        chk({tag, "_err"},   lsu_err_o,    32'd0);
        chk({tag, "_rdata"}, lsu_rdata_o,  32'd0);
        chk({tag, "_req"},   data_req_o,   32'd0);
        chk({tag, "_addr"},  data_addr_o,  32'd0);
        chk({tag, "_we"},    data_we_o,    32'd0);
        chk({tag, "_be"},    data_be_o,    32'd0);
        chk({tag, "_wdata"}, data_wdata_o, 32'd0);
    endtask

    initial begin
        logic [1:0]  w;
        logic [31:0] a;
        rst_i          = 1'b1;
        lsu_req_i      = 1'b0;
        lsu_we_i       = 1'b0;
        lsu_width_i    = 2'b00;
        lsu_unsigned_i = 1'b0;
        lsu_addr_i     = 32'd0;
        lsu_wdata_i    = 32'd0;
        data_gnt_i     = 1'b0;
        data_rvalid_i  = 1'b0;
        data_rdata_i   = 32'd0;
        data_err_i     = 1'b0;
        model_rdata    = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        rst_i = 1'b0;

        // Word load, immediate grant and response.
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        chk("w_load", lsu_rdata_o, 32'hDEAD_BEEF);
        // Byte load, top lane, signed then unsigned.
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 0, 0, 1'b0, 32'h8011_2233);
        chk("b_signed", lsu_rdata_o, 32'hFFFF_FF80);
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'd0, 0, 0, 1'b0, 32'h8011_2233);
        chk("b_unsigned", lsu_rdata_o, 32'h0000_0080);
        // Half store with a 3-cycle grant delay.
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 3, 0, 1'b0, 32'd0);
        chk("h_store_hold", lsu_rdata_o, 32'h0000_0080);
        // Misaligned word load.
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'd0, 0, 0, 1'b0, 32'd0);
        // Bus error on load leaves the load data untouched.
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0, 1, 2, 1'b1, 32'h1234_5678);
        chk("berr_hold", lsu_rdata_o, 32'h0000_0080);

        // Reset while waiting for the response, then a late rvalid.
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_width_i = 2'd2;
        lsu_addr_i  = 32'h0000_0300;
        @(posedge clk);
        @(negedge clk);
        lsu_req_i  = 1'b0;
        data_gnt_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_gnt_i = 1'b0;
        chk("pre_rst_busy", lsu_busy_o, 32'd1);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("mid_rst");
        rst_i         = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        data_rvalid_i = 1'b0;
        model_rdata   = 32'd0;
        chk("late_done",  lsu_done_o,  32'd0);
        chk("late_busy",  lsu_busy_o,  32'd0);
        chk("late_rdata", lsu_rdata_o, 32'd0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0306, 32'd0, 0, 0, 1'b0, 32'h9876_5432);
        chk("post_rst_load", lsu_rdata_o, 32'hFFFF_9876);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            w = 2'($urandom_range(0, 3));
            a = $urandom;
            // Bias toward legal alignment so most accesses reach the bus.
            if ($urandom_range(0, 3) != 0) begin
                if (w == 2'd1) a[0] = 1'b0;
                if (w == 2'd2) a[1:0] = 2'b00;
            end
            run_txn(1'($urandom), w, 1'($urandom), a, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 5) == 0), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
